// File: rtl/weight_loader_pkg.sv
// Shared sizing and state encoding for the horizontal weight-buffer row loader.
package weight_loader_pkg;

    localparam int unsigned ROW_NUM  = 32;
    localparam int unsigned COL_NUM  = 32;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned WPR      = COL_NUM * 8 / DATA_W;
    localparam int unsigned ROW_BITS = COL_NUM * 8;
    localparam int unsigned ROW_W    = $clog2(ROW_NUM);
    localparam int unsigned CNT_W    = ROW_W + 1;
    localparam int unsigned WCNT_W   = (WPR > 1) ? $clog2(WPR) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/wl_row_assembler.sv
// Collects WPR stream words into one PE-array row and flags the final word of the row.
module wl_row_assembler
    import weight_loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                word_valid,
    input  logic [DATA_W-1:0]   word,
    output logic [ROW_BITS-1:0] row,
    output logic                last_word
);

    logic [ROW_BITS-1:0] row_q;
    logic [WCNT_W-1:0]   word_cnt_q;

    assign last_word = (word_cnt_q == WCNT_W'(WPR - 1));
    assign row       = row_q;

    // Clearing only rewinds the word pointer; row_q keeps its last contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q      <= '0;
            word_cnt_q <= '0;
        end else if (clear) begin
            word_cnt_q <= '0;
        end else if (word_valid) begin
            row_q[word_cnt_q * DATA_W +: DATA_W] <= word;
            word_cnt_q <= last_word ? '0 : word_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/weight_row_loader.sv
// Streams weights into a row register and writes a programmable range of rows into the
// horizontal weight buffer, one one-hot strobe per row.
module weight_row_loader
    import weight_loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [ROW_W-1:0]            row_start,
    input  logic [CNT_W-1:0]            row_count,
    output logic                        busy,
    output logic                        done,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_W-1:0]           s_data,
    output logic [ROW_NUM-1:0]          weight_en,
    output logic [ROW_NUM*ROW_BITS-1:0] weight_in
);

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   cur_row_q, cur_row_d;
    logic [CNT_W-1:0]   rows_left_q, rows_left_d;
    logic               asm_clear;
    logic               accept;
    logic               last_word;
    logic [ROW_BITS-1:0] row_data;

    assign accept = s_valid && s_ready;

    wl_row_assembler u_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .word_valid (accept),
        .word       (s_data),
        .row        (row_data),
        .last_word  (last_word)
    );

    // Every row slice sees the same data; only the strobed row captures it.
    assign weight_in = {ROW_NUM{row_data}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_row_q   <= '0;
            rows_left_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_row_q   <= cur_row_d;
            rows_left_q <= rows_left_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_row_d   = cur_row_q;
        rows_left_d = rows_left_q;
        s_ready     = 1'b0;
        weight_en   = '0;
        done        = 1'b0;
        busy        = 1'b0;
        asm_clear   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    asm_clear = 1'b1;
                    if (row_count != '0) begin
                        cur_row_d   = row_start;
                        rows_left_d = row_count;
                        state_d     = FILL;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FILL: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (s_valid && last_word) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy        = 1'b1;
                weight_en   = ROW_NUM'(1) << cur_row_q;
                rows_left_d = rows_left_q - 1'b1;
                cur_row_d   = (cur_row_q == ROW_W'(ROW_NUM - 1)) ? '0 : cur_row_q + 1'b1;
                state_d     = (rows_left_q == CNT_W'(1)) ? DONE : FILL;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything else and drops any partial row.
        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            cur_row_d   = cur_row_q;
            rows_left_d = rows_left_q;
            s_ready     = 1'b0;
            weight_en   = '0;
            done        = 1'b0;
            asm_clear   = 1'b1;
        end
    end

endmodule

// File: tb/tb_weight_row_loader.sv
// Directed bench for weight_row_loader: timing, ordering, wrap, backpressure, abort, reset.
module tb_weight_row_loader;

    localparam int ROWS = 32;
    localparam int RB   = 256;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic [4:0]            row_start = '0;
    logic [5:0]            row_count = '0;
    logic                  busy;
    logic                  done;
    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic [63:0]           s_data;
    logic [ROWS-1:0]       weight_en;
    logic [ROWS*RB-1:0]    weight_in;

    weight_row_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .row_start (row_start),
        .row_count (row_count),
        .busy      (busy),
        .done      (done),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .weight_en (weight_en),
        .weight_in (weight_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int word_idx = 0;
    int n_pass = 0;
    int n_total = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte b of stream word w is (w*8+b) mod 256, so row data is a simple ramp.
    always @(posedge clk) if (s_valid && s_ready) word_idx <= word_idx + 1;
    always_comb begin
        s_data = '0;
        for (int b = 0; b < 8; b++) s_data[b*8 +: 8] = 8'((word_idx * 8 + b) & 255);
    end

    int              en_cyc[$];
    logic [31:0]     en_val[$];
    logic [RB-1:0]   en_row[$];
    int              done_cyc[$];
    int              multi_cnt = 0;
    int              bcast_bad = 0;
    int              sready_cnt = 0;

    always @(negedge clk) begin
        if (weight_en != '0) begin
            en_cyc.push_back(cyc);
            en_val.push_back(weight_en);
            en_row.push_back(weight_in[0 +: RB]);
            if ($countones(weight_en) != 1) multi_cnt++;
        end
        for (int r = 1; r < ROWS; r++)
            if (weight_in[r*RB +: RB] !== weight_in[0 +: RB]) bcast_bad++;
        if (done) done_cyc.push_back(cyc);
        if (s_ready) sready_cnt++;
    end

    function automatic logic [RB-1:0] exp_row(input int w);
        logic [RB-1:0] r;
        for (int c = 0; c < 32; c++) r[c*8 +: 8] = 8'((w * 8 + c) & 255);
        return r;
    endfunction

    task automatic check(input string tag, input logic [RB-1:0] obs, input logic [RB-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input int rs, input int rc);
        row_start = 5'(rs);
        row_count = 6'(rc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    int n_en, n_dn, base, sr0;
    int wrap_rows[4] = '{30, 31, 0, 1};
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        // Reset state
        #1;
        check("rst_en", RB'(weight_en), '0);
        check("rst_win", RB'(weight_in == '0), 1);
        check("rst_busy", RB'(busy), 0);
        check("rst_done", RB'(done), 0);
        check("rst_ready", RB'(s_ready), 0);
        tick(2);
        reset = 1'b0;
        tick(1);

        // Single row 5, continuous stream
        s_valid = 1'b1;
        n_en = en_cyc.size(); n_dn = done_cyc.size();
        pulse_start(5, 1);
        tick(8);
        check("single_cnt", RB'(en_cyc.size() - n_en), 1);
        check("single_en", RB'(en_val[n_en]), 32'h0000_0020);
        check("single_cyc", RB'(en_cyc[n_en]), RB'(start_cyc + 4));
        check("single_row", en_row[n_en],
              256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);
        check("single_done_cnt", RB'(done_cyc.size() - n_dn), 1);
        check("single_done_cyc", RB'(done_cyc[n_dn]), RB'(start_cyc + 5));

        // Full array
        n_en = en_cyc.size(); n_dn = done_cyc.size(); base = word_idx;
        pulse_start(0, 32);
        tick(32 * 5 + 4);
        check("full_cnt", RB'(en_cyc.size() - n_en), 32);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("full_en%0d", k), RB'(en_val[n_en+k]), RB'(32'h1 << k));
            check($sformatf("full_cyc%0d", k), RB'(en_cyc[n_en+k]), RB'(start_cyc + 4 + 5 * k));
            check($sformatf("full_row%0d", k), en_row[n_en+k], exp_row(base + 4 * k));
        end
        check("full_words", RB'(word_idx - base), 128);
        check("full_done_cnt", RB'(done_cyc.size() - n_dn), 1);
        check("full_done_cyc", RB'(done_cyc[n_dn]), RB'(start_cyc + 160));

        // Wrap 30,31,0,1
        n_en = en_cyc.size();
        pulse_start(30, 4);
        tick(25);
        check("wrap_cnt", RB'(en_cyc.size() - n_en), 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("wrap_en%0d", k), RB'(en_val[n_en+k]), RB'(32'h1 << wrap_rows[k]));

        // Backpressure 1,0,0,1,1,0,1 repeating, rows 3 and 4
        n_en = en_cyc.size(); n_dn = done_cyc.size(); base = word_idx;
        pulse_start(3, 2);
        for (int i = 0; i < 20; i++) begin
            s_valid = pat[i % 7][0];
            @(negedge clk);
        end
        s_valid = 1'b1;
        check("bp_cnt", RB'(en_cyc.size() - n_en), 2);
        check("bp_cyc0", RB'(en_cyc[n_en]), RB'(start_cyc + 7));
        check("bp_cyc1", RB'(en_cyc[n_en+1]), RB'(start_cyc + 15));
        check("bp_en0", RB'(en_val[n_en]), 32'h0000_0008);
        check("bp_en1", RB'(en_val[n_en+1]), 32'h0000_0010);
        check("bp_row0", en_row[n_en], exp_row(base));
        check("bp_row1", en_row[n_en+1], exp_row(base + 4));
        check("bp_words", RB'(word_idx - base), 8);
        check("bp_done_cyc", RB'(done_cyc[n_dn]), RB'(start_cyc + 16));

        // Zero row count
        n_en = en_cyc.size(); n_dn = done_cyc.size(); base = word_idx; sr0 = sready_cnt;
        pulse_start(9, 0);
        tick(3);
        check("zero_done_cnt", RB'(done_cyc.size() - n_dn), 1);
        check("zero_done_cyc", RB'(done_cyc[n_dn]), RB'(start_cyc));
        check("zero_ready", RB'(sready_cnt - sr0), 0);
        check("zero_en", RB'(en_cyc.size() - n_en), 0);
        check("zero_words", RB'(word_idx - base), 0);

        // Abort after two words of row 3
        n_en = en_cyc.size(); n_dn = done_cyc.size(); base = word_idx;
        pulse_start(3, 1);
        tick(2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_busy", RB'(busy), 0);
        check("abort_ready", RB'(s_ready), 0);
        tick(6);
        check("abort_words", RB'(word_idx - base), 2);
        check("abort_en", RB'(en_cyc.size() - n_en), 0);
        check("abort_done", RB'(done_cyc.size() - n_dn), 0);
        base = word_idx;
        pulse_start(3, 1);
        tick(6);
        check("post_abort_cnt", RB'(en_cyc.size() - n_en), 1);
        check("post_abort_en", RB'(en_val[n_en]), 32'h0000_0008);
        check("post_abort_cyc", RB'(en_cyc[n_en]), RB'(start_cyc + 4));
        check("post_abort_row", en_row[n_en], exp_row(base));

        // Reset during WRITE
        n_dn = done_cyc.size();
        pulse_start(7, 2);
        tick(4);
        check("rstmid_pre_en", RB'(weight_en), 32'h0000_0080);
        #1 reset = 1'b1;
        #1;
        check("rstmid_en", RB'(weight_en), '0);
        check("rstmid_win", RB'(weight_in == '0), 1);
        check("rstmid_busy", RB'(busy), 0);
        check("rstmid_ready", RB'(s_ready), 0);
        tick(3);
        check("rstmid_done", RB'(done_cyc.size() - n_dn), 0);
        reset = 1'b0;
        tick(2);

        check("multi_hot", RB'(multi_cnt), 0);
        check("broadcast", RB'(bcast_bad), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/weight_row_loader.md
Name: weight_row_loader

Overview:
- Producer side of the horizontal weight-buffer interface.
- Accepts a valid/ready word stream of 8-bit weights from the global buffer, one weight per column, and assembles one full PE-array row at a time.
- Writes each assembled row into the horizontal buffer by driving weight_in and pulsing a one-hot weight_en for the target row.
- Sequences a programmable range of rows and reports busy/done to the layer controller.

Parameters:
- ROW_NUM, 32, PE-array rows (weight_en width)
- COL_NUM, 32, PE-array columns (weights per row)
- DATA_W, 64, stream word width in bits; COL_NUM*8 must be a multiple of DATA_W
- WPR, COL_NUM*8/DATA_W (derived, 4), stream words per row

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse to begin a load; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE and writes nothing further
- row_start  in  $clog2(ROW_NUM)  first target row
- row_count  in  $clog2(ROW_NUM)+1  number of rows to load, 0..ROW_NUM
- busy  out  1  high in FILL/WRITE
- done  out  1  one-cycle pulse at completion
- s_valid  in  1  stream word valid
- s_ready  out  1  stream word accepted when s_valid && s_ready
- s_data  in  DATA_W  stream word; byte b = weight for column (word_idx*DATA_W/8 + b)
- weight_en  out  ROW_NUM  one-hot row write strobe
- weight_in  out  ROW_NUM*COL_NUM*8  row data, broadcast to every row slice

Behaviour:
- Reset values: weight_en=0, weight_in=0 (row register cleared), busy=0, done=0, s_ready=0, state=IDLE, counters=0.
- States: IDLE, FILL, WRITE, DONE.
- IDLE:
  - start && row_count>0 -> latch row_start into cur_row and row_count into rows_left, clear word_cnt, go to FILL.
  - start && row_count==0 -> go to DONE; no stream traffic.
  - Other inputs ignored.
- FILL:
  - s_ready=1.
  - Each accepted word writes row_reg[word_cnt*DATA_W +: DATA_W], then word_cnt increments.
  - Accepting the word with word_cnt==WPR-1 -> WRITE, word_cnt cleared.
  - No acceptance while s_valid=0; state holds.
- WRITE, exactly 1 cycle:
  - s_ready=0.
  - weight_en = 1<<cur_row; all other bits 0.
  - Then rows_left decrements and cur_row increments modulo ROW_NUM (wrap 31->0).
  - rows_left reaching 0 -> DONE; else -> FILL.
- DONE, 1 cycle: done=1, busy=0 -> IDLE.
- weight_in:
  - Combinational broadcast: every row slice r of weight_in equals row_reg.
  - Column c of a slice is bits [c*8 +: 8].
  - row_reg holds its value after WRITE until overwritten, so the buffer only captures the enabled row.
- Throughput: with s_valid held high, WPR+1 cycles per row. N rows take N*(WPR+1) cycles from the first FILL cycle to the last WRITE; done follows one cycle later.
- weight_en is never asserted outside WRITE and is never multi-hot.
- abort:
  - In any non-IDLE state: next state IDLE, weight_en=0, s_ready=0, no done pulse.
  - A partially filled row is discarded.
  - abort has priority over start and stream acceptance in the same cycle.
- A start pulse while not IDLE is ignored (not queued).
- Asynchronous reset mid-operation clears everything to reset values immediately. A buffer write in progress is suppressed because weight_en drops with reset.

Decomposition:
- Package weight_loader_pkg:
  - ROW_NUM, COL_NUM, DATA_W, WPR localparams.
  - state_t enum {IDLE, FILL, WRITE, DONE}.
- Sub-module wl_row_assembler:
  - Owns row_reg and word_cnt.
  - Inputs: clear, word_valid (accepted), word.
  - Outputs: row data and a last_word flag.
- Top-level owns the FSM, the cur_row/rows_left counters, the one-hot decode and the broadcast.

Test Plan:
- Single row:
  - Stimulus: row_start=5, row_count=1; stream words 0x0706050403020100, 0x0F0E..08, 0x1716..10, 0x1F1E..18 with s_valid always high.
  - Response: weight_en=0x00000020 for exactly 1 cycle, on cycle 5 after the first FILL cycle; row 5 column c = c; done 1 cycle later.
- Full array:
  - Stimulus: row_start=0, row_count=32, continuous stream.
  - Response: 32 single-cycle one-hot strobes, 5 cycles apart, in row order 0..31; 128 words consumed; one done pulse.
- Wrap:
  - Stimulus: row_start=30, row_count=4.
  - Response: strobes in order to rows 30, 31, 0, 1.
- Backpressure:
  - Stimulus: s_valid toggles with pattern 1,0,0,1,1,0,1.
  - Response: exactly 4 words accepted per row; word order preserved; weight_en only after the 4th accepted word.
- Zero count and abort:
  - Stimulus A: row_count=0.
    - Response: done on the cycle after start; s_ready never high.
  - Stimulus B: abort after 2 words of row 3.
    - Response: no weight_en; state IDLE; a later start works normally.
- Reset mid-load:
  - Stimulus: assert reset during WRITE.
  - Response: weight_en=0 and weight_in=0 immediately; busy=0; no done pulse.
